cu_if_prefetch: RTL and testbench

//  Parametrised instruction-fetch front end for the CU; successor to the fixed 4-stage IF counter block.

---
 rtl/cu_if_pkg.sv | 15 +
 rtl/cu_if_fifo.sv | 65 ++++++
 rtl/cu_if_prefetch.sv | 154 +++++++++++++++
 tb/tb_cu_if_prefetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_if_pkg.sv
// Shared types and constants for the CU instruction-fetch front end.
package cu_if_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HALT    = 2'd3
  } fetch_state_e;

  localparam logic [3:0]  BYTES_WORD = 4'b1111;
  localparam logic        MEM_READ   = 1'b0;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/cu_if_fifo.sv
// Shift-register prefetch FIFO: head is always slot 0, so the head outputs come straight from flops.
// Vacated slots are kept at zero, which makes an empty head read as all zeros.
module cu_if_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_count_next;
  logic [AW-1:0]    w_wr_idx;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pop        = i_pop & r_valid;
  assign w_push       = i_push & (~w_full | w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  // After a pop the tail moves down one slot, so the write lands one lower.
  assign w_wr_idx     = AW'(w_pop ? (r_count - CW'(1)) : r_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) r_mem[AW'(i)] <= r_mem[AW'(i + 1)];
        r_mem[AW'(DEPTH - 1)] <= '0;
      end
      if (w_push) r_mem[w_wr_idx] <= i_wdata;
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end

  assign o_head  = r_mem[0];
  assign o_valid = r_valid;
  assign o_count = r_count;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    (i_push && !i_flush) |-> (!w_full || (i_pop && r_valid)));

endmodule

// File: rtl/cu_if_prefetch.sv
// Instruction-fetch front end: one-outstanding word reads to the MMU, prefetch FIFO,
// redirect/flush handling and bus-error capture presented to decode.
module cu_if_prefetch #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            soc_clk,
  input  logic            IF_reset_n,
  input  logic            IF_stall,
  input  logic            IF_redirect,
  input  logic [XLEN-1:0] IF_redirect_addr,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_bits_to_access,
  output logic            mem_read_or_write,
  input  logic            mem_ack,
  input  logic [ILEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic            IF_valid,
  output logic [ILEN-1:0] IF_data,
  output logic [XLEN-1:0] IF_pc,
  output logic            IF_fault
);

  import cu_if_pkg::*;

  localparam int unsigned     CW       = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC = {RESET_VEC[XLEN-1:2], 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            fault;
  } entry_t;

  fetch_state_e    r_state, w_state_next;
  logic            r_mem_req, w_req_next;
  logic [XLEN-1:0] r_mem_addr, w_addr_next;
  logic [XLEN-1:0] r_fetch_pc, w_pc_next;

  logic            w_ack, w_push, w_pop, w_slot, w_valid;
  logic [CW-1:0]   w_count, w_count_after;
  logic [XLEN-1:0] w_pc_inc, w_redirect_pc;
  entry_t          w_wdata, w_head;
  logic            w_unused_addr_lsb;

  // An ack only counts while a request is actually on the bus.
  assign w_ack         = mem_ack & r_mem_req;
  assign w_push        = (r_state == REQ) & w_ack & ~IF_redirect;
  assign w_pop         = w_valid & ~IF_stall & ~IF_redirect;
  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
  assign w_slot        = (w_count_after < CW'(DEPTH));
  assign w_pc_inc      = r_fetch_pc + XLEN'(PC_STEP);
  assign w_redirect_pc = {IF_redirect_addr[XLEN-1:2], 2'b00};
  assign w_wdata       = {r_fetch_pc, (mem_err ? ILEN'(0) : mem_rdata), mem_err};
  assign w_unused_addr_lsb = ^IF_redirect_addr[1:0];

  always_ff @(posedge soc_clk or negedge IF_reset_n) begin
    if (!IF_reset_n) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!IF_redirect && w_slot) w_state_next = REQ;
      REQ: begin
        if (IF_redirect)  w_state_next = w_ack ? IDLE : DISCARD;
        else if (w_ack) begin
          if (mem_err)     w_state_next = HALT;
          else if (w_slot) w_state_next = REQ;
          else             w_state_next = IDLE;
        end
      end
      DISCARD: if (w_ack) w_state_next = IDLE;
      HALT:    if (IF_redirect) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of the bus request, its address and the fetch PC.
  always_comb begin
    w_req_next  = 1'b0;
    w_addr_next = r_mem_addr;
    w_pc_next   = IF_redirect ? w_redirect_pc : r_fetch_pc;
    case (r_state)
      IDLE: begin
        if (!IF_redirect && w_slot) begin
          w_req_next  = 1'b1;
          w_addr_next = r_fetch_pc;
        end
      end
      REQ: begin
        if (IF_redirect) begin
          w_req_next = ~w_ack;
        end else if (w_ack) begin
          w_pc_next = w_pc_inc;
          if (!mem_err && w_slot) begin
            w_req_next  = 1'b1;
            w_addr_next = w_pc_inc;
          end
        end else begin
          w_req_next = 1'b1;
        end
      end
      DISCARD: w_req_next = ~w_ack;
      default: w_req_next = 1'b0;
    endcase
  end

  always_ff @(posedge soc_clk or negedge IF_reset_n) begin
    if (!IF_reset_n) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_mem_req  <= w_req_next;
      r_mem_addr <= w_addr_next;
      r_fetch_pc <= w_pc_next;
    end
  end

  cu_if_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (soc_clk),
    .rst_n   (IF_reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (IF_redirect),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign mem_req            = r_mem_req;
  assign mem_addr           = r_mem_addr;
  assign mem_bits_to_access = BYTES_WORD;
  assign mem_read_or_write  = MEM_READ;
  assign IF_valid           = w_valid;
  assign IF_data            = w_head.instr;
  assign IF_pc              = w_head.pc;
  assign IF_fault           = w_head.fault;

  a_addr_aligned: assert property (@(posedge soc_clk) disable iff (!IF_reset_n)
    mem_req |-> (mem_addr[1:0] == 2'b00));
  a_req_held: assert property (@(posedge soc_clk) disable iff (!IF_reset_n)
    (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

endmodule

// File: tb/tb_cu_if_prefetch.sv
// Directed bench for cu_if_prefetch with a behavioural MMU and an in-order scoreboard of fetched words.
module tb_cu_if_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        soc_clk;
  logic        IF_reset_n;
  logic        IF_stall;
  logic        IF_redirect;
  logic [31:0] IF_redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_bits_to_access;
  logic        mem_read_or_write;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        IF_valid;
  logic [31:0] IF_data;
  logic [31:0] IF_pc;
  logic        IF_fault;

  cu_if_prefetch dut (
    .soc_clk            (soc_clk),
    .IF_reset_n         (IF_reset_n),
    .IF_stall           (IF_stall),
    .IF_redirect        (IF_redirect),
    .IF_redirect_addr   (IF_redirect_addr),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_bits_to_access (mem_bits_to_access),
    .mem_read_or_write  (mem_read_or_write),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .mem_err            (mem_err),
    .IF_valid           (IF_valid),
    .IF_data            (IF_data),
    .IF_pc              (IF_pc),
    .IF_fault           (IF_fault)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  int          wait_cnt, mmu_wait, acks, faults_seen;
  logic        err_en, discard, force_ack;
  logic [31:0] err_addr;
  logic        stall_v, redir_v;
  logic [31:0] redir_addr_v;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'hC0DE_1234) + 32'h0000_0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic bench_reset_state();
    sb.delete();
    exp_pc   = 32'h0;
    wait_cnt = 0;
    discard  = 1'b0;
  endtask

  // One clock: check the head, play the MMU, drive inputs, then return just after the posedge.
  task automatic tick();
    exp_t e;
    logic ack_v;
    @(negedge soc_clk);
    if (!IF_valid) begin
      chk("idle_pc", IF_pc, 32'h0);
      chk("idle_data", IF_data, 32'h0);
      chk("idle_fault", 32'(IF_fault), 32'h0);
    end else if (!stall_v && !redir_v) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("head_pc", IF_pc, e.pc);
        chk("head_data", IF_data, e.instr);
        chk("head_fault", 32'(IF_fault), 32'(e.fault));
        if (IF_fault) faults_seen++;
      end
    end
    ack_v = 1'b0;
    if (force_ack) begin
      ack_v     = 1'b1;
      force_ack = 1'b0;
    end else if (mem_req) begin
      if (wait_cnt >= mmu_wait) begin
        ack_v    = 1'b1;
        wait_cnt = 0;
        if (discard) begin
          discard = 1'b0;
        end else begin
          chk("mem_addr", mem_addr, exp_pc);
          if (!redir_v) begin
            chk("no_overflow", 32'(sb.size() < DEPTH), 32'h1);
            e.pc    = exp_pc;
            e.fault = err_en && (exp_pc == err_addr);
            e.instr = e.fault ? 32'h0 : word_of(exp_pc);
            sb.push_back(e);
            exp_pc = exp_pc + 32'd4;
            acks++;
          end
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (redir_v) begin
      if (mem_req && !ack_v) discard = 1'b1;
      sb.delete();
      exp_pc = redir_addr_v & ~32'd3;
    end
    mem_ack          = ack_v;
    mem_rdata        = (ack_v && mem_req) ? word_of(mem_addr) : 32'hDEAD_BEEF;
    mem_err          = ack_v && err_en && (mem_addr == err_addr);
    IF_stall         = stall_v;
    IF_redirect      = redir_v;
    IF_redirect_addr = redir_addr_v;
    @(posedge soc_clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redir_addr_v = a;
    redir_v      = 1'b1;
    tick();
    redir_v      = 1'b0;
  endtask

  initial begin
    logic [31:0] old_addr;
    int n;
    IF_reset_n = 1'b0;
    IF_stall = 1'b0; IF_redirect = 1'b0; IF_redirect_addr = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    stall_v = 1'b1; redir_v = 1'b0; redir_addr_v = 32'h0;
    mmu_wait = 0; acks = 0; faults_seen = 0;
    err_en = 1'b0; err_addr = 32'h8; force_ack = 1'b0;
    bench_reset_state();

    repeat (3) tick();
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(IF_valid), 32'h0);
    chk("rst_be", 32'(mem_bits_to_access), 32'hF);
    chk("rst_rw", 32'(mem_read_or_write), 32'h0);
    IF_reset_n = 1'b1;

    // Stalled decode: FIFO fills to DEPTH, requests stop, head stays at the reset PC.
    repeat (10) tick();
    chk("stall_req_off", 32'(mem_req), 32'h0);
    chk("stall_head_valid", 32'(IF_valid), 32'h1);
    chk("stall_head_pc", IF_pc, 32'h0);
    chk("stall_fill", 32'(acks), 32'(DEPTH));

    // Free-running zero-wait stream, then a random stall pattern.
    stall_v = 1'b0;
    repeat (20) tick();
    repeat (30) begin
      stall_v = ($urandom_range(0, 2) == 0);
      tick();
    end
    stall_v = 1'b0;
    repeat (4) tick();

    // Redirect while a slow request is outstanding: its data must be dropped.
    mmu_wait = 3;
    n = 0;
    while (!(mem_req && wait_cnt < mmu_wait) && n < 20) begin tick(); n++; end
    chk("t3_req_found", 32'(mem_req), 32'h1);
    old_addr = exp_pc;
    redirect_to(32'h0000_0103);
    chk("t3_discard_req", 32'(mem_req), 32'h1);
    chk("t3_discard_addr", mem_addr, old_addr);
    chk("t3_flushed", 32'(IF_valid), 32'h0);
    repeat (5) tick();
    mmu_wait = 0;
    n = 0;
    while (!IF_valid && n < 20) begin tick(); n++; end
    chk("t3_head_pc", IF_pc, 32'h0000_0100);
    repeat (4) tick();

    // Bus error at 0x8: fault entry, then no more requests.
    err_en = 1'b1;
    redirect_to(32'h0);
    repeat (8) tick();
    repeat (6) begin
      tick();
      chk("t4_halt_noreq", 32'(mem_req), 32'h0);
    end
    chk("t4_fault_seen", 32'(faults_seen), 32'h1);
    chk("t4_drained", 32'(IF_valid), 32'h0);
    err_en = 1'b0;

    // Redirect latency and PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    chk("lat0_valid", 32'(IF_valid), 32'h0);
    chk("lat0_req", 32'(mem_req), 32'h0);
    tick();
    chk("lat1_valid", 32'(IF_valid), 32'h0);
    chk("lat1_req", 32'(mem_req), 32'h1);
    chk("lat1_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("lat2_valid", 32'(IF_valid), 32'h1);
    chk("lat2_pc", IF_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", mem_addr, 32'h0);
    repeat (10) tick();

    // Reset in the middle of a request, followed by a stray ack.
    mmu_wait = 3;
    n = 0;
    while (!(mem_req && wait_cnt < mmu_wait) && n < 20) begin tick(); n++; end
    chk("t6_req_found", 32'(mem_req), 32'h1);
    IF_reset_n = 1'b0;
    bench_reset_state();
    #1;
    chk("t6_rst_req", 32'(mem_req), 32'h0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_valid", 32'(IF_valid), 32'h0);
    chk("t6_rst_pc", IF_pc, 32'h0);
    repeat (2) tick();
    IF_reset_n = 1'b1;
    mmu_wait  = 0;
    force_ack = 1'b1;
    tick();
    chk("t6_late_ack_ignored", 32'(IF_valid), 32'h0);
    chk("t6_first_req", 32'(mem_req), 32'h1);
    chk("t6_first_addr", mem_addr, 32'h0);
    tick();
    chk("t6_first_valid", 32'(IF_valid), 32'h1);
    chk("t6_first_pc", IF_pc, 32'h0);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
